sdpram_reader: RTL and testbench
================================

SDPRAM_READER -- requirements
Module: sdpram_reader

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, data width; AW, default 2, RAM address width (DEPTH = 1<<AW).
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-005 base  input  AW  first RAM address of the burst; sampled with start.
REQ-006 len  input  AW+1  number of words to read; sampled with start.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse at burst completion.
REQ-009 ram_ren  output  1  read enable to the SDPRAM read port.
REQ-010 ram_raddr  output  AW  read address to the SDPRAM read port.
REQ-011 ram_dout  input  WIDTH  SDPRAM read data, valid exactly one clock after ram_ren high.
REQ-012 m_valid  output  1  stream data valid.
REQ-013 m_ready  input  1  stream sink ready.
REQ-014 m_data  output  WIDTH  stream data.
REQ-015 m_last  output  1  marks the final word of the burst; qualified by m_valid.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE->RUN on start with len>0; IDLE->DONE on start with len==0, so that no ram_ren is issued.
REQ-018 In RUN, ram_ren SHALL assert only when remaining>0 and (buffered + in-flight - pop this cycle) < 2.
REQ-019 The i-th read SHALL use address (base + i) mod DEPTH, with wrap-around from DEPTH-1 to 0.
REQ-020 len > DEPTH SHALL be legal; addresses keep wrapping and words repeat.
REQ-021 RUN->DRAIN in the cycle the last read issues; DRAIN->DONE on the handshake of the m_last beat.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE; busy=0 in DONE.
REQ-023 Each ram_dout word SHALL be captured into a 2-entry output buffer the cycle after its ram_ren; no word is dropped or duplicated under any m_ready pattern.
REQ-024 Stream rules:
  - m_data/m_last SHALL hold stable while m_valid=1 and m_ready=0.
  - m_valid SHALL not depend combinationally on m_ready.
REQ-025 With m_ready held high, throughput SHALL be one word per cycle; first m_valid 2 cycles after start.
REQ-026 start while not IDLE SHALL be ignored.
REQ-027 ram_raddr SHALL hold its last value when ram_ren=0.

Reset
REQ-028 While reset=0, outputs SHALL be: busy=0, done=0, ram_ren=0, ram_raddr=0, m_valid=0, m_data=0, m_last=0; FSM in IDLE; buffer empty.
REQ-029 Reset asserted mid-burst SHALL abort immediately. No done SHALL follow, and in-flight RAM data SHALL be discarded.

Structure
REQ-030 State encoding localparams (IDLE=0, RUN=1, DRAIN=2, DONE=3) SHALL live in a shared package/header used by RTL and bench.
REQ-031 The 2-entry output buffer SHALL be a sub-module named sdpram_rd_skid, with the same clock/reset ports.
REQ-032 The SDPRAM itself SHALL NOT be instantiated inside sdpram_reader; it is connected externally.

Verification (bench instantiates SDPRAM with DEPTH=4, WIDTH=8, preloaded A0,A1,A2,A3)
REQ-033 start, base=0, len=4, m_ready=1 -> m_data A0,A1,A2,A3 on 4 consecutive cycles; m_last on A3; done 1 cycle after A3.
REQ-034 base=3, len=3 -> A3,A0,A1 (wrap); ram_raddr sequence 3,0,1.
REQ-035 base=0, len=4, m_ready toggling 1,0,0,1,... -> same 4 words in order, data stable while stalled, never more than 2 reads outstanding.
REQ-036 len=0 -> no ram_ren, no m_valid, done pulse one cycle after start.
REQ-037 reset low mid-burst after 2 words -> all outputs 0 immediately; no done; next start base=1, len=2 -> A1,A2.
REQ-038 start pulsed during RUN -> ignored; burst completes unchanged with exactly one done.

Source files
------------

// File: rtl/sdpram_reader_pkg.sv
// Shared definitions for the SDPRAM burst reader: FSM state encoding.
package sdpram_reader_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_RUN_ENC   = 2'd1;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_RUN   = ST_RUN_ENC,
        ST_DRAIN = ST_DRAIN_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_e;

endpackage

// File: rtl/sdpram_rd_skid.sv
// Two-entry output buffer between the RAM read data and the stream port.
// Slot 0 is always the head and drives the stream outputs directly from
// registers, so data/last stay stable while the head is not popped.
module sdpram_rd_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             push_last_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] data0_q, data1_q;
    logic             last0_q, last1_q;
    logic [1:0]       count_q;

    // Push into the first free slot, shift slot 1 into slot 0 on pop.
    // pop_i is only asserted while the head is valid, and the reader never
    // pushes into a full buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        data0_q <= push_data_i;
                        last0_q <= push_last_i;
                    end else begin
                        data1_q <= push_data_i;
                        last1_q <= push_last_i;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    data0_q <= data1_q;
                    last0_q <= last1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        data0_q <= push_data_i;
                        last0_q <= push_last_i;
                    end else begin
                        data0_q <= data1_q;
                        last0_q <= last1_q;
                        data1_q <= push_data_i;
                        last1_q <= push_last_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = data0_q;
    assign last_o  = last0_q;
    assign count_o = count_q;

endmodule

// File: rtl/sdpram_reader.sv
// Burst reader: issues len reads from an external SDPRAM starting at base
// (wrapping modulo DEPTH) and streams the words out with valid/ready.
// Reads are throttled so that buffered plus in-flight words never exceed
// the two-entry output buffer.
module sdpram_reader
    import sdpram_reader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [AW-1:0]    base_i,
    input  logic [AW:0]      len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             ram_ren_o,
    output logic [AW-1:0]    ram_raddr_o,
    input  logic [WIDTH-1:0] ram_dout_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_last_o
);

    state_e          state_q;
    logic [AW:0]     rem_q;
    logic [AW-1:0]   next_addr_q;
    logic [AW-1:0]   last_addr_q;
    logic            rvalid_q;
    logic            rlast_q;

    logic [1:0]      buf_count;
    logic [1:0]      occ;
    logic            pop;
    logic            issue;
    logic            issue_last;

    assign pop = m_valid_o & m_ready_i;

    // Words that will still occupy the buffer after this edge, not counting
    // a read issued now; a new read is allowed only if it still fits.
    assign occ        = buf_count + {1'b0, rvalid_q} - {1'b0, pop};
    assign issue      = (state_q == ST_RUN) && (rem_q != '0) && (occ < 2'd2);
    assign issue_last = issue && (rem_q == (AW+1)'(1));

    assign ram_ren_o   = issue;
    // Address presented while reading; otherwise keep the last one issued.
    assign ram_raddr_o = issue ? next_addr_q : last_addr_q;

    assign busy_o = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o = (state_q == ST_DONE);

    // Burst control FSM with address/length counters and read-data tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            next_addr_q <= '0;
            last_addr_q <= '0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
        end else begin
            rvalid_q <= issue;
            rlast_q  <= issue_last;
            if (issue) begin
                next_addr_q <= next_addr_q + AW'(1);
                last_addr_q <= next_addr_q;
                rem_q       <= rem_q - (AW+1)'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        next_addr_q <= base_i;
                        rem_q       <= len_i;
                        state_q     <= (len_i == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue_last) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pop && m_last_o) state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sdpram_rd_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (rvalid_q),
        .push_data_i (ram_dout_i),
        .push_last_i (rlast_q),
        .pop_i       (pop),
        .valid_o     (m_valid_o),
        .data_o      (m_data_o),
        .last_o      (m_last_o),
        .count_o     (buf_count)
    );

endmodule

// File: tb/tb_sdpram_reader.sv
// Randomized self-checking bench for sdpram_reader with an external
// 4-word SDPRAM model preloaded with A0..A3.
module tb_sdpram_reader;
    import sdpram_reader_pkg::*;

    localparam int WIDTH = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [AW-1:0]    base;
    logic [AW:0]      len;
    logic             busy, done, ram_ren;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_dout;
    logic             m_valid, m_ready, m_last;
    logic [WIDTH-1:0] m_data;

    logic [WIDTH-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;
    logic [AW-1:0] last_addr;

    sdpram_reader #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .base_i      (base),
        .len_i       (len),
        .busy_o      (busy),
        .done_o      (done),
        .ram_ren_o   (ram_ren),
        .ram_raddr_o (ram_raddr),
        .ram_dout_i  (ram_dout),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_data_o    (m_data),
        .m_last_o    (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External SDPRAM: registered read, data one clock after ren.
    always @(posedge clk) begin
        if (ram_ren) ram_dout <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    32'(busy),      0);
        chk({tag, "_done"},    32'(done),      0);
        chk({tag, "_ren"},     32'(ram_ren),   0);
        chk({tag, "_raddr"},   32'(ram_raddr), 0);
        chk({tag, "_valid"},   32'(m_valid),   0);
        chk({tag, "_data"},    32'(m_data),    0);
        chk({tag, "_last"},    32'(m_last),    0);
    endtask

    // One burst. mode: 0 ready high, 1 ready pattern 1,0,0, 2 random ready.
    // abort_beats > 0 pulls reset once that many beats were handshaken.
    // inject pulses a second start while the burst is running.
    task automatic run_burst(input int b, input int l, input int mode,
                             input int abort_beats, input bit inject);
        logic [WIDTH-1:0] exp_data [$];
        logic [AW-1:0]    exp_addr [$];
        int beats    = 0;
        int outst    = 0;
        int first_v  = -1;
        int done_idx = -1;
        bit prev_stall = 1'b0;
        for (int i = 0; i < l; i++) begin
            exp_data.push_back(mem[(b + i) % DEPTH]);
            exp_addr.push_back(AW'((b + i) % DEPTH));
        end
        $display("burst base=%0d len=%0d mode=%0d abort=%0d inject=%0d", b, l, mode, abort_beats, inject);

        @(negedge clk);
        start = 1'b1;
        base  = AW'(b);
        len   = (AW+1)'(l);
        for (int k = 0; k < 200 && done_idx < 0; k++) begin
            @(negedge clk);
            if (abort_beats > 0 && beats >= abort_beats) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero("abort");
                repeat (2) begin
                    @(negedge clk);
                    #1;
                    chk("abort_no_done", 32'(done), 0);
                    chk("abort_no_valid", 32'(m_valid), 0);
                end
                rst_n = 1'b1;
                last_addr = '0;
                return;
            end
            start = (inject && k == 1);
            if (inject && k == 1) begin
                base = base + AW'(2);
                len  = (AW+1)'(1);
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (k % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (k == 0) begin
                if (l == 0) chk("done_after_start", 32'(done), 1);
                else        chk("busy_after_start", 32'(busy), 1);
            end
            // Stream side first: a handshake this cycle frees a slot.
            if (m_valid) begin
                if (first_v < 0) first_v = k;
                if (exp_data.size() == 0) begin
                    chk("extra_valid", 1, 0);
                end else begin
                    chk("m_data", 32'(m_data), 32'(exp_data[0]));
                    chk("m_last", 32'(m_last), 32'(exp_data.size() == 1));
                    if (m_ready) begin
                        void'(exp_data.pop_front());
                        beats++;
                        outst--;
                    end
                end
            end else if (prev_stall) begin
                chk("valid_held", 0, 1);
            end
            prev_stall = m_valid && !m_ready;
            // Read side.
            if (ram_ren) begin
                if (exp_addr.size() == 0) begin
                    chk("extra_ren", 1, 0);
                end else begin
                    last_addr = exp_addr.pop_front();
                    chk("raddr", 32'(ram_raddr), 32'(last_addr));
                    outst++;
                    chk("outstanding_le_2", 32'(outst <= 2), 1);
                end
            end else begin
                chk("raddr_hold", 32'(ram_raddr), 32'(last_addr));
            end
            if (done) begin
                done_idx = k;
                chk("beats_at_done", 32'(beats), 32'(l));
                chk("data_left", 32'(exp_data.size()), 0);
                chk("addr_left", 32'(exp_addr.size()), 0);
                chk("busy_in_done", 32'(busy), 0);
            end
        end
        start = 1'b0;
        if (done_idx < 0) chk("timeout", 0, 1);
        if (mode == 0) begin
            chk("first_valid_cycle", 32'(first_v), (l == 0) ? 32'hFFFF_FFFF : 32'd2);
            chk("done_cycle", 32'(done_idx), (l == 0) ? 32'd0 : 32'(2 + l));
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("post_done", 32'(done), 0);
            chk("post_busy", 32'(busy), 0);
            chk("post_ren", 32'(ram_ren), 0);
            chk("post_valid", 32'(m_valid), 0);
        end
    endtask

    initial begin
        mem[0] = 8'hA0;
        mem[1] = 8'hA1;
        mem[2] = 8'hA2;
        mem[3] = 8'hA3;
        ram_dout  = '0;
        last_addr = '0;
        start   = 1'b0;
        base    = '0;
        len     = '0;
        m_ready = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset_held");
        rst_n = 1'b1;

        run_burst(0, 4, 0, 0, 1'b0);   // straight burst, full throughput
        run_burst(3, 3, 0, 0, 1'b0);   // wrap 3,0,1
        run_burst(0, 4, 1, 0, 1'b0);   // stalled sink
        run_burst(0, 0, 0, 0, 1'b0);   // empty burst
        run_burst(0, 4, 0, 2, 1'b0);   // reset after two words
        run_burst(1, 2, 0, 0, 1'b0);   // clean restart
        run_burst(0, 4, 0, 0, 1'b1);   // start ignored while running
        run_burst(2, 7, 1, 0, 1'b0);   // len beyond depth
        for (int t = 0; t < 12; t++) begin
            run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 2)), 0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
